// File: rtl/trace_pkg.sv
// Shared trace constants and the retire record layout used by the retire tracker.
package trace_pkg;

  localparam logic [31:0] HALT_INST = 32'h0000_0000;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam int          REC_W     = 64;

  typedef logic [REC_W-1:0] rec_t;

  // Record layout: PC in the upper word, instruction in the lower word.
  function automatic rec_t mk_rec(input logic [31:0] pc, input logic [31:0] inst);
    return {pc, inst};
  endfunction

endpackage

// File: rtl/retire_fifo.sv
// Retire-record FIFO: power-of-two depth, wrapping pointers, separate occupancy count.
module retire_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  rec_t wdata_i,
  output rec_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == CNT_FULL);
  assign empty_o = (count == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop on the same edge frees the slot, so full+pop+push never drops.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/retire_tracker.sv
// Shadows the CPU EX/MEM/WB slots, reports retirements, counts them and
// queues {pc, inst} records on a valid/ready drain port.
module retire_tracker
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] id_inst_i,
  input  logic [31:0] id_pc_i,
  input  logic        id_stall_i,
  input  logic        id_flush_i,
  output logic        retire_valid_o,
  output logic [31:0] retire_pc_o,
  output logic [31:0] retire_inst_o,
  output logic [31:0] retire_count_o,
  output logic        halt_o,
  output logic        overflow_o,
  output logic        rec_valid_o,
  output logic [31:0] rec_pc_o,
  output logic [31:0] rec_inst_o,
  input  logic        rec_ready_i
);

  localparam int STAGES = 2;
  localparam int WB     = 2;

  // Slot 0 = EX, 1 = MEM, 2 = WB.
  logic [STAGES:0]       vld_pipe;
  logic [STAGES:0][31:0] pc_pipe;
  logic [STAGES:0][31:0] inst_pipe;

  logic retire_evt;
  logic halt_evt;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;
  logic drop;
  rec_t fifo_rdata;

  assign retire_evt = start_i && vld_pipe[WB];
  assign halt_evt   = retire_evt && (inst_pipe[WB] == HALT_INST);
  assign fifo_pop   = rec_valid_o && rec_ready_i;
  assign fifo_push  = retire_evt;
  assign drop       = retire_evt && fifo_full && !rec_ready_i;

  // Flush and stall both just invalidate the EX entry, so priority is moot here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe  <= '0;
      pc_pipe   <= '0;
      inst_pipe <= '0;
    end else if (halt_evt) begin
      vld_pipe  <= '0;
    end else if (start_i && !halt_o) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], (!id_stall_i && !id_flush_i)};
      pc_pipe   <= {pc_pipe[STAGES-1:0], id_pc_i};
      inst_pipe <= {inst_pipe[STAGES-1:0], id_inst_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retire_count_o <= '0;
      halt_o         <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      if (retire_evt && (retire_count_o != 32'hFFFF_FFFF))
        retire_count_o <= retire_count_o + 32'd1;
      if (halt_evt) halt_o     <= 1'b1;
      if (drop)     overflow_o <= 1'b1;
    end
  end

  retire_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (mk_rec(pc_pipe[WB], inst_pipe[WB])),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign retire_valid_o = vld_pipe[WB];
  assign retire_pc_o    = pc_pipe[WB];
  assign retire_inst_o  = inst_pipe[WB];
  assign rec_valid_o    = !fifo_empty;
  assign rec_pc_o       = fifo_rdata[REC_W-1:32];
  assign rec_inst_o     = fifo_rdata[31:0];

endmodule

// File: doc/retire_tracker.md
RETIRE_TRACKER -- requirements
Module: retire_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of retire-FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start_i, input, 1 bit: run enable; when 0, all tracker state holds.
REQ-005 SHALL have port id_inst_i, input, 32 bits: instruction currently in the CPU ID stage.
REQ-006 SHALL have port id_pc_i, input, 32 bits: PC of the ID-stage instruction.
REQ-007 SHALL have port id_stall_i, input, 1 bit: hazard stall; the ID instruction is held and a bubble enters EX.
REQ-008 SHALL have port id_flush_i, input, 1 bit: the ID instruction is squashed (branch/jump flush).
REQ-009 SHALL have port retire_valid_o, output, 1 bit: the WB slot holds a real instruction this cycle.
REQ-010 SHALL have ports retire_pc_o and retire_inst_o, output, 32 bits each: WB slot contents.
REQ-011 SHALL have port retire_count_o, output, 32 bits: number of instructions retired.
REQ-012 SHALL have port halt_o, output, 1 bit: sticky flag, set when the end marker (instruction 32'h0) retires.
REQ-013 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a retire record is dropped because the FIFO is full.
REQ-014 SHALL have ports rec_valid_o (output, 1 bit), rec_pc_o (output, 32 bits), rec_inst_o (output, 32 bits) and rec_ready_i (input, 1 bit): valid/ready drain port for retire records.

Function
REQ-015 SHALL keep three shadow slots, EX, MEM and WB, each holding {valid, pc, inst}.
REQ-016 SHALL, on each edge with start_i=1 and halt_o=0, shift the slots: WB<=MEM, MEM<=EX, and EX<={!id_stall_i && !id_flush_i, id_pc_i, id_inst_i}.
REQ-017 SHALL make a flush take priority over a stall; in either case the EX slot becomes invalid.
REQ-018 SHALL drive retire_valid_o, retire_pc_o and retire_inst_o directly from the WB slot registers (no combinational path from the inputs).
REQ-019 SHALL define a retire event as: the WB slot is valid at a rising edge while start_i=1.
REQ-020 SHALL, on a retire event, push {pc, inst} into the FIFO and increment retire_count_o, saturating at 32'hFFFFFFFF.
REQ-021 SHALL give a latency from ID capture (edge N) to retire_valid_o high after edge N+2, and to rec_valid_o high after edge N+3.
REQ-022 SHALL treat a retire event with inst==32'h0 as a normal record (pushed and counted) and also: set halt_o, clear all three slot valids, and stop further capture until reset.
REQ-023 SHALL keep the drain port operating while halted, so the FIFO can be emptied after halt.
REQ-024 SHALL, when the FIFO is full and rec_ready_i=0 on a retire event, drop the record, set overflow_o, and still increment retire_count_o.
REQ-025 SHALL, when the FIFO is full and rec_ready_i=1 on a retire event, pop and push on the same edge with no drop.
REQ-026 SHALL, when the FIFO is empty, drive rec_valid_o=0; a push into an empty FIFO is not visible on the same edge (no bypass).
REQ-027 SHALL pop on an edge where rec_valid_o=1 and rec_ready_i=1; rec_pc_o and rec_inst_o stay stable while rec_valid_o=1 and rec_ready_i=0.
REQ-028 SHALL wrap the FIFO read/write pointers modulo DEPTH and track occupancy with a separate count of width log2(DEPTH)+1.

Reset
REQ-029 SHALL, on rst_i=1 at a rising edge, clear all slot valids, the FIFO pointers and count, retire_count_o, halt_o and overflow_o; slot pc/inst SHALL reset to 0.
REQ-030 SHALL give reset priority over every other event, including a retire event on the same edge; after a mid-operation reset, rec_valid_o=0 and retire_valid_o=0 from the next cycle.

Structure
REQ-031 SHALL take HALT_INST (32'h00000000), NOP_INST (32'h00000013) and the record width (64) from the shared package trace_pkg.
REQ-032 SHALL implement the FIFO as one sub-module, retire_fifo (parameter DEPTH, push/pop/full/empty), with the slot shifting, counter and flags in retire_tracker.

Verification
REQ-033 SHALL verify straight-line flow: PCs 0x10008, 0x1000C and 0x10010 enter with no stall, rec_ready_i=1 -> records appear in order on consecutive cycles starting 3 edges after the first capture, and retire_count_o=3.
REQ-034 SHALL verify stall and flush: id_stall_i=1 for one cycle, then id_flush_i=1 for one cycle -> two bubbles, no records for those cycles, and retire_count_o excludes them.
REQ-035 SHALL verify halt: inst 32'h0 at PC 0x10020 retires -> a record is pushed, halt_o=1, and later ID inputs are ignored, with retire_count_o frozen.
REQ-036 SHALL verify backpressure: rec_ready_i=0 with 5 retires and DEPTH=4 -> 4 records held, overflow_o=1, retire_count_o=5; raising rec_ready_i then drains exactly 4 records.
REQ-037 SHALL verify full-with-simultaneous-pop: FIFO full, rec_ready_i=1, one retire -> no overflow and occupancy stays 4.
REQ-038 SHALL verify mid-run reset: rst_i=1 asserted while the FIFO holds 2 records -> all outputs 0 on the next cycle.
